conv_unit_scheduler: RTL and testbench

Sequencing controller for the convolution unit (SA_UNITS systolic arrays plus adder tree, bias, accumulate and ReLU). For each output pixel of each output channel, it walks the input-channel groups (SA_UNITS channels per pass). Per pass it requests operand fetch, runs one calculate pass and feeds the partial result back as output_temp. After the last group it writes the finished pixel out. Sits between the layer controller (start/done, config) and the line/weight buffers (fetch) and output buffer (write).

---
 rtl/conv_sched_pkg.sv | 24 ++
 rtl/conv_loop_nest.sv | 64 ++++++
 rtl/conv_unit_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_conv_unit_scheduler.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
// rtl/conv_sched_pkg.sv - shared types and default widths for the conv unit scheduler
package conv_sched_pkg;

    localparam int CH_W   = 8;
    localparam int DIM_W  = 8;
    localparam int ADDR_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CALC,
        S_ACCUM,
        S_WRITE,
        S_FIN
    } sched_state_t;

    typedef struct packed {
        logic [CH_W-1:0]  groups;
        logic [CH_W-1:0]  out_ch;
        logic [DIM_W-1:0] out_h;
        logic [DIM_W-1:0] out_w;
    } sched_cfg_t;

endpackage

// File: rtl/conv_loop_nest.sv
// rtl/conv_loop_nest.sv - col/row/oc pixel counters with last flag and output address
module conv_loop_nest #(
    parameter int CH_W   = 8,
    parameter int DIM_W  = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_advance,
    input  logic [CH_W-1:0]   i_out_ch,
    input  logic [DIM_W-1:0]  i_out_h,
    input  logic [DIM_W-1:0]  i_out_w,
    output logic [CH_W-1:0]   o_oc,
    output logic [DIM_W-1:0]  o_row,
    output logic [DIM_W-1:0]  o_col,
    output logic              o_last,
    output logic [ADDR_W-1:0] o_addr
);

    logic [CH_W-1:0]  r_oc;
    logic [DIM_W-1:0] r_row;
    logic [DIM_W-1:0] r_col;
    logic             w_col_wrap;
    logic             w_row_wrap;
    logic             w_oc_wrap;

    assign w_col_wrap = (r_col == i_out_w - DIM_W'(1));
    assign w_row_wrap = (r_row == i_out_h - DIM_W'(1));
    assign w_oc_wrap  = (r_oc == i_out_ch - CH_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_oc  <= '0;
            r_row <= '0;
            r_col <= '0;
        end else if (i_clear) begin
            r_oc  <= '0;
            r_row <= '0;
            r_col <= '0;
        end else if (i_advance) begin
            // col is innermost; each wrap carries one level outward
            if (w_col_wrap) begin
                r_col <= '0;
                if (w_row_wrap) begin
                    r_row <= '0;
                    r_oc  <= w_oc_wrap ? '0 : r_oc + CH_W'(1);
                end else begin
                    r_row <= r_row + DIM_W'(1);
                end
            end else begin
                r_col <= r_col + DIM_W'(1);
            end
        end
    end

    assign o_oc   = r_oc;
    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = w_col_wrap && w_row_wrap && w_oc_wrap;
    assign o_addr = (ADDR_W'(r_oc) * ADDR_W'(i_out_h) + ADDR_W'(r_row)) * ADDR_W'(i_out_w)
                    + ADDR_W'(r_col);

endmodule

// File: rtl/conv_unit_scheduler.sv
// rtl/conv_unit_scheduler.sv - pass/pixel sequencing FSM driving fetch, calculate and write-out
module conv_unit_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int SA_UNITS   = 4,
    parameter int CH_W       = conv_sched_pkg::CH_W,
    parameter int DIM_W      = conv_sched_pkg::DIM_W,
    parameter int ADDR_W     = conv_sched_pkg::ADDR_W,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CH_W-1:0]       cfg_groups,
    input  logic [CH_W-1:0]       cfg_out_ch,
    input  logic [DIM_W-1:0]      cfg_out_h,
    input  logic [DIM_W-1:0]      cfg_out_w,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  fetch_req,
    output logic [CH_W-1:0]       fetch_oc,
    output logic [CH_W-1:0]       fetch_grp,
    output logic [DIM_W-1:0]      fetch_row,
    output logic [DIM_W-1:0]      fetch_col,
    input  logic                  fetch_ack,
    input  logic [DATA_WIDTH-1:0] bias_in,
    output logic                  calculate,
    input  logic                  all_done,
    input  logic [DATA_WIDTH-1:0] conv_result,
    output logic [DATA_WIDTH-1:0] bias,
    output logic [DATA_WIDTH-1:0] output_temp,
    output logic                  wr_valid,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_ready
);
    import conv_sched_pkg::*;

    localparam int WD_W = $clog2(TIMEOUT + 1);

    if (SA_UNITS < 1) begin : g_sa_check
        $error("SA_UNITS must be at least 1");
    end

    sched_state_t           r_state;
    sched_state_t           w_next;
    sched_cfg_t             r_cfg;
    logic [CH_W-1:0]        r_grp;
    logic [DATA_WIDTH-1:0]  r_acc;
    logic [DATA_WIDTH-1:0]  r_bias;
    logic [DATA_WIDTH-1:0]  r_temp;
    logic [WD_W-1:0]        r_wd;
    logic                   r_error;

    logic                   w_cfg_zero;
    logic                   w_grp_last;
    logic                   w_accept;
    logic                   w_fetch_take;
    logic                   w_timeout;
    logic                   w_advance;
    logic                   w_last;
    logic [CH_W-1:0]        w_oc;
    logic [DIM_W-1:0]       w_row;
    logic [DIM_W-1:0]       w_col;
    logic [ADDR_W-1:0]      w_addr;

    assign w_cfg_zero = (cfg_groups == '0) || (cfg_out_ch == '0) ||
                        (cfg_out_h == '0) || (cfg_out_w == '0);
    assign w_grp_last = (r_grp == r_cfg.groups - CH_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_fetch_take = 1'b0;
        w_timeout    = 1'b0;
        w_advance    = 1'b0;
        fetch_req    = 1'b0;
        calculate    = 1'b0;
        wr_valid     = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = w_cfg_zero ? S_FIN : S_FETCH;
                end
            end
            S_FETCH: begin
                fetch_req = 1'b1;
                if (fetch_ack) begin
                    w_fetch_take = 1'b1;
                    w_next       = S_CALC;
                end
            end
            S_CALC: begin
                calculate = 1'b1;
                // r_wd is 0 only in the first CALC cycle, where a stale all_done is ignored
                if (all_done && (r_wd != '0)) begin
                    w_next = S_ACCUM;
                end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
                    w_timeout = 1'b1;
                    w_next    = S_FIN;
                end
            end
            S_ACCUM: begin
                w_next = w_grp_last ? S_WRITE : S_FETCH;
            end
            S_WRITE: begin
                wr_valid = 1'b1;
                if (wr_ready) begin
                    w_advance = 1'b1;
                    w_next    = w_last ? S_FIN : S_FETCH;
                end
            end
            S_FIN: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg   <= '0;
            r_grp   <= '0;
            r_acc   <= '0;
            r_bias  <= '0;
            r_temp  <= '0;
            r_wd    <= '0;
            r_error <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cfg.groups <= cfg_groups;
                r_cfg.out_ch <= cfg_out_ch;
                r_cfg.out_h  <= cfg_out_h;
                r_cfg.out_w  <= cfg_out_w;
                r_grp        <= '0;
                r_acc        <= '0;
                r_bias       <= '0;
                r_temp       <= '0;
                r_error      <= 1'b0;
            end
            // bias only enters on the first group; later groups chain the running sum
            if (w_fetch_take) begin
                r_bias <= (r_grp == '0) ? bias_in : '0;
                r_temp <= (r_grp == '0) ? '0 : r_acc;
            end
            if ((r_state == S_CALC) && (w_next == S_CALC)) begin
                r_wd <= r_wd + WD_W'(1);
            end else begin
                r_wd <= '0;
            end
            if (w_timeout) begin
                r_error <= 1'b1;
            end
            if (r_state == S_ACCUM) begin
                r_acc <= conv_result;
                r_grp <= w_grp_last ? '0 : r_grp + CH_W'(1);
            end
        end
    end

    conv_loop_nest #(
        .CH_W   (CH_W),
        .DIM_W  (DIM_W),
        .ADDR_W (ADDR_W)
    ) u_loop_nest (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_accept),
        .i_advance (w_advance),
        .i_out_ch  (r_cfg.out_ch),
        .i_out_h   (r_cfg.out_h),
        .i_out_w   (r_cfg.out_w),
        .o_oc      (w_oc),
        .o_row     (w_row),
        .o_col     (w_col),
        .o_last    (w_last),
        .o_addr    (w_addr)
    );

    assign busy        = (r_state != S_IDLE);
    assign error       = r_error;
    assign fetch_oc    = w_oc;
    assign fetch_grp   = r_grp;
    assign fetch_row   = w_row;
    assign fetch_col   = w_col;
    assign bias        = r_bias;
    assign output_temp = r_temp;
    assign wr_addr     = w_addr;
    assign wr_data     = r_acc;

endmodule

// File: tb/tb_conv_unit_scheduler.sv
// tb/tb_conv_unit_scheduler.sv - self-checking bench for conv_unit_scheduler
module tb_conv_unit_scheduler;

    localparam int DW = 16;
    localparam int CW = 8;
    localparam int MW = 8;
    localparam int AW = 16;
    localparam int TO = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] cfg_groups, cfg_out_ch;
    logic [MW-1:0] cfg_out_h, cfg_out_w;
    logic          busy, done, error;
    logic          fetch_req;
    logic [CW-1:0] fetch_oc, fetch_grp;
    logic [MW-1:0] fetch_row, fetch_col;
    logic          fetch_ack;
    logic [DW-1:0] bias_in;
    logic          calculate;
    logic          all_done;
    logic [DW-1:0] conv_result;
    logic [DW-1:0] bias, output_temp;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;

    conv_unit_scheduler #(
        .DATA_WIDTH (DW), .SA_UNITS (4), .CH_W (CW), .DIM_W (MW),
        .ADDR_W (AW), .TIMEOUT (TO)
    ) dut (
        .clk (clk), .rst_n (rst_n), .start (start),
        .cfg_groups (cfg_groups), .cfg_out_ch (cfg_out_ch),
        .cfg_out_h (cfg_out_h), .cfg_out_w (cfg_out_w),
        .busy (busy), .done (done), .error (error),
        .fetch_req (fetch_req), .fetch_oc (fetch_oc), .fetch_grp (fetch_grp),
        .fetch_row (fetch_row), .fetch_col (fetch_col), .fetch_ack (fetch_ack),
        .bias_in (bias_in), .calculate (calculate), .all_done (all_done),
        .conv_result (conv_result), .bias (bias), .output_temp (output_temp),
        .wr_valid (wr_valid), .wr_addr (wr_addr), .wr_data (wr_data),
        .wr_ready (wr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int       ack_delay, done_delay, wr_delay;
    bit       en_done;
    logic [DW-1:0] bias_val;
    logic [DW-1:0] res_tab [64];
    int       res_idx;

    int nfetch, ncalc, nwr, ndone, npass, nfreq_cyc, nwv_cyc;
    int f_unstable, w_unstable, c_unstable;
    logic [CW-1:0] f_oc [64];
    logic [CW-1:0] f_grp [64];
    logic [MW-1:0] f_row [64];
    logic [MW-1:0] f_col [64];
    logic [DW-1:0] c_bias [64];
    logic [DW-1:0] c_temp [64];
    logic [AW-1:0] w_addr_log [64];
    logic [DW-1:0] w_data_log [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        nfetch = 0; ncalc = 0; nwr = 0; ndone = 0; npass = 0;
        nfreq_cyc = 0; nwv_cyc = 0;
        f_unstable = 0; w_unstable = 0; c_unstable = 0;
        res_idx = 0;
    endtask

    // Environment model: acks fetches, completes passes and accepts writes per the knobs, and logs traffic
    initial begin : responder
        int fcnt, ccnt, wcnt;
        bit done_given, prev_freq, prev_wv, prev_calc;
        logic [2*CW+2*MW-1:0] p_fidx;
        logic [AW+DW-1:0]     p_wr;
        fcnt = 0; ccnt = 0; wcnt = 0;
        done_given = 0; prev_freq = 0; prev_wv = 0; prev_calc = 0;
        p_fidx = '0; p_wr = '0;
        fetch_ack = 0; bias_in = '0; all_done = 0; conv_result = '0; wr_ready = 0;
        forever begin
            @(negedge clk);
            if (fetch_req) begin
                fetch_ack = (fcnt >= ack_delay);
                bias_in   = fetch_ack ? bias_val : 16'hDEAD;
                fcnt++;
            end else begin
                fetch_ack = 0;
                fcnt = 0;
            end
            if (calculate) begin
                conv_result = res_tab[res_idx % 64];
                all_done = en_done && (ccnt >= done_delay);
                if (all_done) done_given = 1;
                ccnt++;
            end else begin
                all_done = 0;
                ccnt = 0;
                if (done_given) begin
                    res_idx++;
                    done_given = 0;
                end
            end
            if (wr_valid) begin
                wr_ready = (wcnt >= wr_delay);
                wcnt++;
            end else begin
                wr_ready = 0;
                wcnt = 0;
            end

            if (fetch_req) begin
                nfreq_cyc++;
                if (prev_freq && ({fetch_oc, fetch_grp, fetch_row, fetch_col} != p_fidx))
                    f_unstable++;
                if (fetch_ack && nfetch < 64) begin
                    f_oc[nfetch] = fetch_oc; f_grp[nfetch] = fetch_grp;
                    f_row[nfetch] = fetch_row; f_col[nfetch] = fetch_col;
                end
                if (fetch_ack) nfetch++;
            end
            prev_freq = fetch_req && !fetch_ack;
            p_fidx = {fetch_oc, fetch_grp, fetch_row, fetch_col};

            if (calculate) begin
                if (!prev_calc) begin
                    if (npass < 64) begin
                        c_bias[npass] = bias;
                        c_temp[npass] = output_temp;
                    end
                    npass++;
                end else if (npass <= 64 &&
                             (bias != c_bias[npass-1] || output_temp != c_temp[npass-1])) begin
                    c_unstable++;
                end
                ncalc++;
            end
            prev_calc = calculate;

            if (wr_valid) begin
                nwv_cyc++;
                if (prev_wv && ({wr_addr, wr_data} != p_wr)) w_unstable++;
                if (wr_ready && nwr < 64) begin
                    w_addr_log[nwr] = wr_addr;
                    w_data_log[nwr] = wr_data;
                end
                if (wr_ready) nwr++;
            end
            prev_wv = wr_valid && !wr_ready;
            p_wr = {wr_addr, wr_data};

            if (done) ndone++;
        end
    end

    task automatic run_layer(input int g, input int ch, input int h, input int w,
                             input int bound, input bit poke_busy, input bit poke_fin,
                             output int lat, output bit err_at_done, output bit err_after_start);
        clear_logs();
        cfg_groups = CW'(g); cfg_out_ch = CW'(ch);
        cfg_out_h = MW'(h); cfg_out_w = MW'(w);
        start = 1;
        tick();
        start = 0;
        cfg_groups = 8'd7; cfg_out_ch = 8'd7; cfg_out_h = 8'd7; cfg_out_w = 8'd7;
        err_after_start = error;
        lat = 1;
        while (!done && lat < bound) begin
            if (poke_busy && lat == 3) start = 1;
            tick();
            start = 0;
            lat++;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_wait: no done within %0d cycles", bound);
        end
        err_at_done = error;
        if (poke_fin) start = 1;
        tick();
        start = 0;
        check("busy_after_done", busy, 0);
    endtask

    typedef struct {
        int g, ch, h, w;
        int e_fetch, e_wr, e_calc, e_lat;
    } vec_t;

    function automatic bit outs_nonzero();
        return |{busy, done, error, fetch_req, calculate, wr_valid, fetch_oc, fetch_grp,
                 fetch_row, fetch_col, bias, output_temp, wr_addr, wr_data};
    endfunction

    initial begin : main
        vec_t vecs [7];
        int   lat, bad;
        bit   e_done, e_start;

        vecs[0] = '{1, 1, 1, 1,  1,  1,  2, -1};
        vecs[1] = '{1, 2, 2, 3, 12, 12, 24, -1};
        vecs[2] = '{3, 1, 1, 1,  3,  1,  6, -1};
        vecs[3] = '{2, 1, 1, 2,  4,  2,  8, -1};
        vecs[4] = '{1, 1, 1, 0,  0,  0,  0,  1};
        vecs[5] = '{0, 2, 2, 2,  0,  0,  0,  1};
        vecs[6] = '{2, 0, 1, 1,  0,  0,  0,  1};

        rst_n = 0; start = 0;
        cfg_groups = '0; cfg_out_ch = '0; cfg_out_h = '0; cfg_out_w = '0;
        ack_delay = 0; done_delay = 0; wr_delay = 0; en_done = 1; bias_val = 16'h3C00;
        for (int i = 0; i < 64; i++) res_tab[i] = 16'h1000 + 16'(i);
        clear_logs();
        repeat (3) tick();
        check("reset_outputs", outs_nonzero(), 0);
        rst_n = 1;
        tick();

        // Table: all_done is high from the first CALC cycle, so each pass takes 2 calc cycles
        for (int i = 0; i < 7; i++) begin
            run_layer(vecs[i].g, vecs[i].ch, vecs[i].h, vecs[i].w, 400, 0, 0, lat, e_done, e_start);
            check($sformatf("v%0d_fetches", i), nfetch, vecs[i].e_fetch);
            check($sformatf("v%0d_writes", i), nwr, vecs[i].e_wr);
            check($sformatf("v%0d_calc_cycles", i), ncalc, vecs[i].e_calc);
            check($sformatf("v%0d_done_count", i), ndone, 1);
            check($sformatf("v%0d_error", i), e_done, 0);
            if (vecs[i].e_lat >= 0) check($sformatf("v%0d_latency", i), lat, vecs[i].e_lat);
            bad = 0;
            if (vecs[i].g != 0) begin
                for (int k = 0; k < nwr && k < 64; k++) begin
                    if (w_addr_log[k] != AW'(k)) bad++;
                    if (w_data_log[k] != res_tab[k * vecs[i].g + vecs[i].g - 1]) bad++;
                end
                for (int k = 0; k < nfetch && k < 64; k++) begin
                    int p, gi;
                    p  = k / vecs[i].g;
                    gi = k % vecs[i].g;
                    if (f_grp[k] != CW'(gi)) bad++;
                    if (f_col[k] != MW'(p % vecs[i].w)) bad++;
                    if (f_row[k] != MW'((p / vecs[i].w) % vecs[i].h)) bad++;
                    if (f_oc[k] != CW'(p / (vecs[i].w * vecs[i].h))) bad++;
                    if (c_bias[k] != ((gi == 0) ? bias_val : 16'h0000)) bad++;
                    if (c_temp[k] != ((gi == 0) ? 16'h0000 : res_tab[k - 1])) bad++;
                end
            end
            check($sformatf("v%0d_sequence_errors", i), bad, 0);
        end

        // Basic pixel
        done_delay = 3; bias_val = 16'h3C00; res_tab[0] = 16'h4000;
        run_layer(1, 1, 1, 1, 100, 0, 0, lat, e_done, e_start);
        check("basic_fetches", nfetch, 1);
        check("basic_calc_bias", c_bias[0], 16'h3C00);
        check("basic_calc_temp", c_temp[0], 16'h0000);
        check("basic_calc_cycles", ncalc, 4);
        check("basic_writes", nwr, 1);
        check("basic_wr_addr", w_addr_log[0], 0);
        check("basic_wr_data", w_data_log[0], 16'h4000);
        check("basic_done", ndone, 1);

        // Group accumulation
        done_delay = 1; bias_val = 16'h3555;
        res_tab[0] = 16'h3C00; res_tab[1] = 16'h4000; res_tab[2] = 16'h4200;
        run_layer(3, 1, 1, 1, 100, 0, 0, lat, e_done, e_start);
        check("grp_temp0", c_temp[0], 16'h0000);
        check("grp_temp1", c_temp[1], 16'h3C00);
        check("grp_temp2", c_temp[2], 16'h4000);
        check("grp_bias0", c_bias[0], 16'h3555);
        check("grp_bias1", c_bias[1], 16'h0000);
        check("grp_bias2", c_bias[2], 16'h0000);
        check("grp_calc_stable", c_unstable, 0);
        check("grp_writes", nwr, 1);
        check("grp_wr_data", w_data_log[0], 16'h4200);

        // Backpressure on fetch and write
        ack_delay = 4; wr_delay = 5; done_delay = 2;
        res_tab[0] = 16'h1111; res_tab[1] = 16'h2222;
        run_layer(1, 1, 1, 2, 200, 0, 0, lat, e_done, e_start);
        check("bp_fetches", nfetch, 2);
        check("bp_fetch_req_cycles", nfreq_cyc, 10);
        check("bp_fetch_stable", f_unstable, 0);
        check("bp_wr_valid_cycles", nwv_cyc, 12);
        check("bp_wr_stable", w_unstable, 0);
        check("bp_calc_cycles", ncalc, 6);
        check("bp_wr_data1", w_data_log[1], 16'h2222);
        check("bp_wr_addr1", w_addr_log[1], 1);
        ack_delay = 0; wr_delay = 0; done_delay = 1;

        // Start while busy and start during FIN are ignored
        run_layer(1, 1, 1, 2, 200, 1, 0, lat, e_done, e_start);
        check("busy_start_writes", nwr, 2);
        check("busy_start_done", ndone, 1);
        run_layer(1, 1, 1, 0, 50, 0, 1, lat, e_done, e_start);
        check("zero_latency", lat, 1);
        check("zero_no_activity", nfreq_cyc + ncalc + nwv_cyc, 0);

        // Watchdog timeout, sticky error, cleared by next start
        en_done = 0;
        run_layer(1, 1, 1, 1, 100, 0, 0, lat, e_done, e_start);
        check("to_error_at_done", e_done, 1);
        check("to_calc_cycles", ncalc, TO);
        check("to_writes", nwr, 0);
        check("to_done", ndone, 1);
        tick();
        check("to_error_sticky", error, 1);
        en_done = 1;
        run_layer(1, 1, 1, 1, 100, 0, 0, lat, e_done, e_start);
        check("to_error_cleared", e_start, 0);
        check("to_recover_writes", nwr, 1);

        // Async reset in the middle of CALC
        en_done = 0; bias_val = 16'h3C00;
        clear_logs();
        cfg_groups = 1; cfg_out_ch = 1; cfg_out_h = 1; cfg_out_w = 1;
        start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 20 && !calculate; i++) tick();
        check("rst_reached_calc", calculate, 1);
        repeat (3) tick();
        rst_n = 0;
        #1;
        check("rst_outputs_zero", outs_nonzero(), 0);
        repeat (3) tick();
        rst_n = 1;
        en_done = 1;
        repeat (5) tick();
        check("rst_no_write", nwr, 0);
        check("rst_no_done", ndone, 0);
        check("rst_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
